// File: rtl/operand_buffer.sv
// Multi-thread operand staging buffer: one first-word-fall-through FIFO per thread,
// valid/ready handshake on both sides and a per-thread squash.
module operand_buffer #(
  parameter int NUM_THREADS = 2,
  parameter int DEPTH       = 2,
  parameter int WORD_WIDTH  = 32,
  parameter int CR_WIDTH    = 4,
  parameter int TID_WIDTH   = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [TID_WIDTH-1:0]   wr_thread,
  input  logic [WORD_WIDTH-1:0]  wr_a,
  input  logic [WORD_WIDTH-1:0]  wr_b,
  input  logic [WORD_WIDTH-1:0]  wr_c,
  input  logic                   wr_cin,
  input  logic [CR_WIDTH-1:0]    wr_cr,
  input  logic [TID_WIDTH-1:0]   rd_thread,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [WORD_WIDTH-1:0]  rd_a,
  output logic [WORD_WIDTH-1:0]  rd_b,
  output logic [WORD_WIDTH-1:0]  rd_c,
  output logic                   rd_cin,
  output logic [CR_WIDTH-1:0]    rd_cr,
  input  logic [NUM_THREADS-1:0] flush,
  output logic [NUM_THREADS-1:0] empty,
  output logic [NUM_THREADS-1:0] full
);

  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TID_SPACE = 1 << TID_WIDTH;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] b;
    logic [WORD_WIDTH-1:0] c;
    logic                  cin;
    logic [CR_WIDTH-1:0]   cr;
  } bundle_t;

  bundle_t          mem   [NUM_THREADS][DEPTH];
  logic [PTR_W-1:0] head  [NUM_THREADS];
  logic [PTR_W-1:0] tail  [NUM_THREADS];
  logic [CNT_W-1:0] count [NUM_THREADS];

  // Per-thread acceptance flags, padded to the full id space so that
  // unused ids index a zero bit instead of needing a range compare.
  logic [TID_SPACE-1:0]   wr_ok;
  logic [TID_SPACE-1:0]   rd_ok;
  logic [NUM_THREADS-1:0] wr_sel;
  logic [NUM_THREADS-1:0] rd_sel;
  bundle_t                wr_bundle;
  bundle_t                head_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty = '0;
    full  = '0;
    wr_ok = '0;
    rd_ok = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      empty[t] = (count[t] == '0);
      full[t]  = (count[t] == CNT_W'(DEPTH));
      wr_ok[t] = !full[t] && !flush[t];
      rd_ok[t] = !empty[t] && !flush[t];
    end
  end

  assign wr_ready = wr_ok[wr_thread];
  assign rd_valid = rd_ok[rd_thread];

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      wr_sel[t] = wr_valid && wr_ready && (wr_thread == TID_WIDTH'(t));
      rd_sel[t] = rd_ready && rd_valid && (rd_thread == TID_WIDTH'(t));
    end
  end

  always_comb begin
    head_q = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (rd_valid && (rd_thread == TID_WIDTH'(t))) begin
        head_q = mem[t][head[t]];
      end
    end
  end

  assign wr_bundle = '{a: wr_a, b: wr_b, c: wr_c, cin: wr_cin, cr: wr_cr};
  assign rd_a      = head_q.a;
  assign rd_b      = head_q.b;
  assign rd_c      = head_q.c;
  assign rd_cin    = head_q.cin;
  assign rd_cr     = head_q.cr;

  always_ff @(posedge clk) begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (wr_sel[t]) begin
        mem[t][tail[t]] <= wr_bundle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        head[t]  <= '0;
        tail[t]  <= '0;
        count[t] <= '0;
      end
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        if (flush[t]) begin
          head[t]  <= '0;
          tail[t]  <= '0;
          count[t] <= '0;
        end else begin
          if (wr_sel[t]) tail[t] <= ptr_next(tail[t]);
          if (rd_sel[t]) head[t] <= ptr_next(head[t]);
          if (wr_sel[t] && !rd_sel[t]) begin
            count[t] <= count[t] + CNT_W'(1);
          end else if (!wr_sel[t] && rd_sel[t]) begin
            count[t] <= count[t] - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_buffer.sv
// Bench for operand_buffer: a 2x2 instance and a 3-thread, depth-3 instance,
// each compared against per-thread queue models.
module tb_operand_buffer;
  localparam int W   = 32;
  localparam int CRW = 4;
  localparam int NTA = 2;
  localparam int DA  = 2;
  localparam int NTB = 3;
  localparam int DB  = 3;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic           cin;
    logic [CRW-1:0] cr;
  } bnd_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           a_wr_valid, a_wr_ready, a_rd_ready, a_rd_valid, a_rd_cin;
  logic [0:0]     a_wr_thread, a_rd_thread;
  logic [NTA-1:0] a_flush, a_empty, a_full;
  logic [W-1:0]   a_rd_a, a_rd_b, a_rd_c;
  logic [CRW-1:0] a_rd_cr;
  bnd_t           a_wd, a_rd;

  logic           b_wr_valid, b_wr_ready, b_rd_ready, b_rd_valid, b_rd_cin;
  logic [1:0]     b_wr_thread, b_rd_thread;
  logic [NTB-1:0] b_flush, b_empty, b_full;
  logic [W-1:0]   b_rd_a, b_rd_b, b_rd_c;
  logic [CRW-1:0] b_rd_cr;
  bnd_t           b_wd, b_rd;

  assign a_rd = {a_rd_a, a_rd_b, a_rd_c, a_rd_cin, a_rd_cr};
  assign b_rd = {b_rd_a, b_rd_b, b_rd_c, b_rd_cin, b_rd_cr};

  operand_buffer #(.NUM_THREADS(NTA), .DEPTH(DA), .WORD_WIDTH(W), .CR_WIDTH(CRW)) dut_a (
    .clk(clk), .reset(reset),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_thread(a_wr_thread),
    .wr_a(a_wd.a), .wr_b(a_wd.b), .wr_c(a_wd.c), .wr_cin(a_wd.cin), .wr_cr(a_wd.cr),
    .rd_thread(a_rd_thread), .rd_ready(a_rd_ready), .rd_valid(a_rd_valid),
    .rd_a(a_rd_a), .rd_b(a_rd_b), .rd_c(a_rd_c), .rd_cin(a_rd_cin), .rd_cr(a_rd_cr),
    .flush(a_flush), .empty(a_empty), .full(a_full)
  );

  operand_buffer #(.NUM_THREADS(NTB), .DEPTH(DB), .WORD_WIDTH(W), .CR_WIDTH(CRW)) dut_b (
    .clk(clk), .reset(reset),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_thread(b_wr_thread),
    .wr_a(b_wd.a), .wr_b(b_wd.b), .wr_c(b_wd.c), .wr_cin(b_wd.cin), .wr_cr(b_wd.cr),
    .rd_thread(b_rd_thread), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid),
    .rd_a(b_rd_a), .rd_b(b_rd_b), .rd_c(b_rd_c), .rd_cin(b_rd_cin), .rd_cr(b_rd_cr),
    .flush(b_flush), .empty(b_empty), .full(b_full)
  );

  // Reference model: an ordered queue of bundles per thread.
  bnd_t qa[NTA][$];
  bnd_t qb[NTB][$];

  function automatic logic exp_wr_ready_a();
    return (qa[a_wr_thread].size() < DA) && !a_flush[a_wr_thread];
  endfunction
  function automatic logic exp_rd_valid_a();
    return (qa[a_rd_thread].size() > 0) && !a_flush[a_rd_thread];
  endfunction
  function automatic bnd_t exp_rd_a();
    return exp_rd_valid_a() ? qa[a_rd_thread][0] : '0;
  endfunction
  function automatic logic [NTA-1:0] exp_empty_a();
    logic [NTA-1:0] e;
    for (int t = 0; t < NTA; t++) e[t] = (qa[t].size() == 0);
    return e;
  endfunction
  function automatic logic [NTA-1:0] exp_full_a();
    logic [NTA-1:0] f;
    for (int t = 0; t < NTA; t++) f[t] = (qa[t].size() == DA);
    return f;
  endfunction

  function automatic logic exp_wr_ready_b();
    int t = int'(b_wr_thread);
    if (t >= NTB) return 1'b0;
    return (qb[t].size() < DB) && !b_flush[t];
  endfunction
  function automatic logic exp_rd_valid_b();
    int t = int'(b_rd_thread);
    if (t >= NTB) return 1'b0;
    return (qb[t].size() > 0) && !b_flush[t];
  endfunction
  function automatic bnd_t exp_rd_b();
    return exp_rd_valid_b() ? qb[int'(b_rd_thread)][0] : '0;
  endfunction
  function automatic logic [NTB-1:0] exp_empty_b();
    logic [NTB-1:0] e;
    for (int t = 0; t < NTB; t++) e[t] = (qb[t].size() == 0);
    return e;
  endfunction
  function automatic logic [NTB-1:0] exp_full_b();
    logic [NTB-1:0] f;
    for (int t = 0; t < NTB; t++) f[t] = (qb[t].size() == DB);
    return f;
  endfunction

  function automatic bnd_t rnd_bnd();
    bnd_t r;
    r.a   = $urandom;
    r.b   = $urandom;
    r.c   = $urandom;
    r.cin = 1'($urandom);
    r.cr  = 4'($urandom);
    return r;
  endfunction

  task automatic idle();
    a_wr_valid = 1'b0; a_rd_ready = 1'b0; a_flush = '0;
    a_wr_thread = '0;  a_rd_thread = '0;  a_wd = rnd_bnd();
    b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_flush = '0;
    b_wr_thread = '0;  b_rd_thread = '0;  b_wd = rnd_bnd();
  endtask

  // Advance one clock and apply the handshakes the model says fire.
  task automatic tick();
    logic wa, ra, wb, rb;
    int wta, rta, wtb, rtb;
    bnd_t da, db;
    logic [NTA-1:0] fa;
    logic [NTB-1:0] fb;
    wa = a_wr_valid && exp_wr_ready_a();
    ra = a_rd_ready && exp_rd_valid_a();
    wb = b_wr_valid && exp_wr_ready_b();
    rb = b_rd_ready && exp_rd_valid_b();
    wta = int'(a_wr_thread); rta = int'(a_rd_thread);
    wtb = int'(b_wr_thread); rtb = int'(b_rd_thread);
    da = a_wd; db = b_wd; fa = a_flush; fb = b_flush;
    @(posedge clk);
    for (int t = 0; t < NTA; t++) if (fa[t]) qa[t].delete();
    for (int t = 0; t < NTB; t++) if (fb[t]) qb[t].delete();
    if (ra) void'(qa[rta].pop_front());
    if (wa) qa[wta].push_back(da);
    if (rb) void'(qb[rtb].pop_front());
    if (wb) qb[wtb].push_back(db);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1;
    checks++; if (a_empty !== 2'b11) begin failures++; $display("FAIL reset_empty_a got=%b exp=11", a_empty); end
    checks++; if (a_full !== 2'b00) begin failures++; $display("FAIL reset_full_a got=%b exp=00", a_full); end
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
    checks++; if (a_rd !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", a_rd); end
    checks++; if (a_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready_t0 got=%b exp=1", a_wr_ready); end
    a_wr_thread = 1'b1; #1;
    checks++; if (a_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready_t1 got=%b exp=1", a_wr_ready); end
    b_wr_thread = 2'd2; #1;
    checks++; if (b_empty !== 3'b111) begin failures++; $display("FAIL reset_empty_b got=%b exp=111", b_empty); end
    checks++; if (b_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready_b_t2 got=%b exp=1", b_wr_ready); end
  endtask

  task automatic test_write_latency();
    bnd_t v;
    v = '{a: 32'h11111111, b: 32'h22, c: 32'h33, cin: 1'b1, cr: 4'h5};
    idle();
    a_wr_valid = 1'b1; a_wr_thread = 1'b0; a_wd = v; a_rd_thread = 1'b0;
    #1;
    checks++; if (a_wr_ready !== 1'b1) begin failures++; $display("FAIL lat_wr_ready got=%b exp=1", a_wr_ready); end
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL lat_no_bypass got=%b exp=0", a_rd_valid); end
    tick();
    a_wr_valid = 1'b0; #1;
    checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL lat_rd_valid got=%b exp=1", a_rd_valid); end
    checks++; if (a_rd !== v) begin failures++; $display("FAIL lat_rd_data got=%h exp=%h", a_rd, v); end
    checks++; if (a_empty !== 2'b10) begin failures++; $display("FAIL lat_empty got=%b exp=10", a_empty); end
    a_rd_ready = 1'b1;
    tick();
    a_rd_ready = 1'b0; #1;
    checks++; if (a_empty !== 2'b11) begin failures++; $display("FAIL lat_pop_empty got=%b exp=11", a_empty); end
  endtask

  task automatic test_fill_full();
    idle();
    a_wr_valid = 1'b1; a_wr_thread = 1'b1;
    a_wd = rnd_bnd(); a_wd.a = 32'hA; tick();
    a_wd = rnd_bnd(); a_wd.a = 32'hB; tick();
    a_wr_valid = 1'b0; #1;
    checks++; if (a_full !== 2'b10) begin failures++; $display("FAIL full_flag got=%b exp=10", a_full); end
    checks++; if (a_wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready_t1 got=%b exp=0", a_wr_ready); end
    a_wr_thread = 1'b0; #1;
    checks++; if (a_wr_ready !== 1'b1) begin failures++; $display("FAIL full_wr_ready_t0 got=%b exp=1", a_wr_ready); end
    a_wr_valid = 1'b1; a_wr_thread = 1'b1; a_wd = rnd_bnd();
    a_rd_thread = 1'b1; a_rd_ready = 1'b1; #1;
    checks++; if (a_wr_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru got=%b exp=0", a_wr_ready); end
    checks++; if (a_rd_a !== 32'hA) begin failures++; $display("FAIL full_pop0 got=%h exp=a", a_rd_a); end
    tick();
    a_wr_valid = 1'b0; #1;
    checks++; if (a_rd_a !== 32'hB) begin failures++; $display("FAIL full_pop1 got=%h exp=b", a_rd_a); end
    checks++; if (a_full !== 2'b00) begin failures++; $display("FAIL full_after_pop got=%b exp=00", a_full); end
    tick();
    a_rd_ready = 1'b0; #1;
    checks++; if (a_empty !== 2'b11) begin failures++; $display("FAIL full_drained got=%b exp=11", a_empty); end
  endtask

  task automatic test_flush();
    bnd_t h1;
    idle();
    a_wr_valid = 1'b1;
    a_wr_thread = 1'b0; a_wd = rnd_bnd(); tick();
    a_wd = rnd_bnd(); tick();
    a_wr_thread = 1'b1; a_wd = rnd_bnd(); tick();
    h1 = qa[1][0];
    a_flush = 2'b01; a_wr_thread = 1'b0; a_wd = rnd_bnd(); a_rd_thread = 1'b1; #1;
    checks++; if (a_wr_ready !== 1'b0) begin failures++; $display("FAIL flush_wr_blocked got=%b exp=0", a_wr_ready); end
    tick();
    a_flush = '0; a_wr_valid = 1'b0; #1;
    checks++; if (a_empty !== 2'b01) begin failures++; $display("FAIL flush_empty got=%b exp=01", a_empty); end
    checks++; if (a_rd_valid !== 1'b1 || a_rd !== h1) begin failures++; $display("FAIL flush_t1_head got=%b/%h exp=1/%h", a_rd_valid, a_rd, h1); end
    a_rd_thread = 1'b0; #1;
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL flush_t0_rd_valid got=%b exp=0", a_rd_valid); end
  endtask

  task automatic test_out_of_range();
    logic [NTB-1:0] e_before;
    idle();
    b_wr_valid = 1'b1;
    b_wr_thread = 2'd0; b_wd = rnd_bnd(); tick();
    b_wr_thread = 2'd2; b_wd = rnd_bnd(); tick();
    e_before = exp_empty_b();
    b_wr_thread = 2'd3; b_rd_thread = 2'd3; b_rd_ready = 1'b1; b_wd = rnd_bnd(); #1;
    checks++; if (b_wr_ready !== 1'b0) begin failures++; $display("FAIL oor_wr_ready got=%b exp=0", b_wr_ready); end
    checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL oor_rd_valid got=%b exp=0", b_rd_valid); end
    checks++; if (b_rd !== '0) begin failures++; $display("FAIL oor_rd_data got=%h exp=0", b_rd); end
    tick();
    idle(); #1;
    checks++; if (b_empty !== e_before) begin failures++; $display("FAIL oor_empty got=%b exp=%b", b_empty, e_before); end
    checks++; if (b_rd !== qb[0][0]) begin failures++; $display("FAIL oor_t0_head got=%h exp=%h", b_rd, qb[0][0]); end
    b_rd_thread = 2'd2; #1;
    checks++; if (b_rd !== qb[2][0]) begin failures++; $display("FAIL oor_t2_head got=%h exp=%h", b_rd, qb[2][0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_wr_valid  = ($urandom_range(3) != 0);
      a_rd_ready  = ($urandom_range(3) != 0);
      a_wr_thread = 1'($urandom);
      a_rd_thread = 1'($urandom);
      a_wd        = rnd_bnd();
      a_flush     = '0;
      for (int t = 0; t < NTA; t++) a_flush[t] = ($urandom_range(15) == 0);
      b_wr_valid  = ($urandom_range(3) != 0);
      b_rd_ready  = ($urandom_range(2) == 0);
      b_wr_thread = 2'($urandom);
      b_rd_thread = 2'($urandom);
      b_wd        = rnd_bnd();
      b_flush     = '0;
      for (int t = 0; t < NTB; t++) b_flush[t] = ($urandom_range(23) == 0);
      #1;
      checks++; if (a_wr_ready !== exp_wr_ready_a()) begin failures++; $display("FAIL rnd_a_wr_ready cyc=%0d got=%b exp=%b", i, a_wr_ready, exp_wr_ready_a()); end
      checks++; if (a_rd_valid !== exp_rd_valid_a()) begin failures++; $display("FAIL rnd_a_rd_valid cyc=%0d got=%b exp=%b", i, a_rd_valid, exp_rd_valid_a()); end
      checks++; if (a_rd !== exp_rd_a()) begin failures++; $display("FAIL rnd_a_rd_data cyc=%0d got=%h exp=%h", i, a_rd, exp_rd_a()); end
      checks++; if (a_empty !== exp_empty_a() || a_full !== exp_full_a()) begin failures++; $display("FAIL rnd_a_flags cyc=%0d got=%b/%b exp=%b/%b", i, a_empty, a_full, exp_empty_a(), exp_full_a()); end
      checks++; if (b_wr_ready !== exp_wr_ready_b()) begin failures++; $display("FAIL rnd_b_wr_ready cyc=%0d got=%b exp=%b", i, b_wr_ready, exp_wr_ready_b()); end
      checks++; if (b_rd_valid !== exp_rd_valid_b()) begin failures++; $display("FAIL rnd_b_rd_valid cyc=%0d got=%b exp=%b", i, b_rd_valid, exp_rd_valid_b()); end
      checks++; if (b_rd !== exp_rd_b()) begin failures++; $display("FAIL rnd_b_rd_data cyc=%0d got=%h exp=%h", i, b_rd, exp_rd_b()); end
      checks++; if (b_empty !== exp_empty_b() || b_full !== exp_full_b()) begin failures++; $display("FAIL rnd_b_flags cyc=%0d got=%b/%b exp=%b/%b", i, b_empty, b_full, exp_empty_b(), exp_full_b()); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle();
    a_wr_valid = 1'b1; b_wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_wr_thread = 1'(i); a_wd = rnd_bnd();
      b_wr_thread = 2'(i % NTB); b_wd = rnd_bnd();
      tick();
    end
    idle();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (a_empty !== 2'b11) begin failures++; $display("FAIL areset_empty_a got=%b exp=11", a_empty); end
    checks++; if (a_full !== 2'b00) begin failures++; $display("FAIL areset_full_a got=%b exp=00", a_full); end
    checks++; if (a_rd_valid !== 1'b0 || a_rd !== '0) begin failures++; $display("FAIL areset_rd got=%b/%h exp=0/0", a_rd_valid, a_rd); end
    checks++; if (b_empty !== 3'b111) begin failures++; $display("FAIL areset_empty_b got=%b exp=111", b_empty); end
    for (int t = 0; t < NTA; t++) qa[t].delete();
    for (int t = 0; t < NTB; t++) qb[t].delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (a_empty !== 2'b11 || b_empty !== 3'b111) begin failures++; $display("FAIL areset_after_edge got=%b/%b exp=11/111", a_empty, b_empty); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_write_latency();
    test_fill_full();
    test_flush();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_buffer.md
# operand_buffer

Parametrised multi-thread operand staging buffer between the operand-fetch stage and the functional units. Generalises the single-thread operand bus (one unregistered bundle for thread 0) to NUM_THREADS threads, each with its own DEPTH-entry first-word-fall-through FIFO of operand bundles (a, b, c, cin, cr). Adds valid/ready handshaking and a per-thread flush for branch and interrupt squashing.

## Interface

Parameters:
- NUM_THREADS, 2, number of hardware threads; must be ≥ 1.
- DEPTH, 2, entries per thread FIFO; must be ≥ 1; need not be a power of 2.
- WORD_WIDTH, 32, width of a, b, c.
- CR_WIDTH, 4, width of the condition-register field.
- TID_WIDTH, max(1, $clog2(NUM_THREADS)), thread-id width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write slot available for wr_thread.
- wr_thread  in  TID_WIDTH  target thread of the write.
- wr_a, wr_b, wr_c  in  WORD_WIDTH each  operand words.
- wr_cin  in  1  carry-in.
- wr_cr  in  CR_WIDTH  CR field.
- rd_thread  in  TID_WIDTH  thread whose head entry is presented.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry of rd_thread is valid.
- rd_a, rd_b, rd_c  out  WORD_WIDTH each  head operands.
- rd_cin  out  1  head carry-in.
- rd_cr  out  CR_WIDTH  head CR field.
- flush  in  NUM_THREADS  per-thread squash bitmask.
- empty  out  NUM_THREADS  per-thread empty flags.
- full  out  NUM_THREADS  per-thread full flags.

## Operation

- Per thread t: storage of DEPTH bundles, head pointer, tail pointer, occupancy count (width $clog2(DEPTH+1)).
- Pointers increment modulo DEPTH: on reaching DEPTH-1 they wrap to 0 (explicit compare, not bit truncation).
- Write: wr_ready = (wr_thread < NUM_THREADS) && !full[wr_thread] && !flush[wr_thread]. Write fires when wr_valid && wr_ready: bundle stored at tail of wr_thread, tail advances, count +1.
- Read: rd_valid = (rd_thread < NUM_THREADS) && !empty[rd_thread] && !flush[rd_thread]. Pop fires when rd_valid && rd_ready: head advances, count -1.
- rd_* data is combinational from the head entry of rd_thread; when rd_valid is 0, rd_a/b/c/cin/cr drive all zeros (deterministic, not X).
- Same thread written and popped in one cycle: both take effect, count unchanged. Different threads: independent.
- No write-to-read bypass: an entry written in cycle n is first visible in cycle n+1.
- Full thread: wr_ready 0 even if the same thread is popped that cycle (no pass-through on full).
- Flush[t]: on the next edge, head, tail and count of t reset to 0; any write or pop addressed to t that cycle is blocked via wr_ready/rd_valid. Other threads unaffected.
- Out-of-range thread ids (NUM_THREADS not a power of 2): wr_ready 0, rd_valid 0, no state change.
- empty[t] = (count==0); full[t] = (count==DEPTH); both registered-state derived, combinational from count.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert assumed by the integrator): all counts, heads, tails = 0; empty = all ones; full = all zeros; wr_ready = 1 for valid in-range thread ids; rd_valid = 0; rd_* = 0. Storage contents need not be reset.
- Reset asserted mid-operation: all threads drop contents immediately; no partial write completes.
- Write-to-read latency: 1 cycle. Pop-to-next-head latency: 0 (next entry presented the cycle after the pop edge).
- wr_ready and rd_valid depend combinationally on wr_thread/rd_thread and flush; they do not depend on wr_valid or rd_ready (no combinational loop through the handshake).
- Sustained throughput per thread: one write and one pop per cycle when 0 < count < DEPTH.

## Test plan

- Reset, then write thread 0 a=0x11111111, b=0x22, c=0x33, cin=1, cr=0x5 in cycle 1 -> rd_valid=0 in cycle 1, rd_valid=1 with identical values in cycle 2 for rd_thread=0; empty=2'b10.
- Fill thread 1 with DEPTH=2 entries 0xA, 0xB -> full[1]=1, wr_ready=0 for wr_thread=1 while wr_ready=1 for wr_thread=0; simultaneous pop of thread 1 with write still rejected; pops return 0xA then 0xB.
- DEPTH=3 build: 7 writes interleaved with pops, occupancy kept at 1–3 -> values read in exact write order across pointer wrap, count never exceeds 3.
- Thread 0 holds 2 entries, thread 1 holds 1; assert flush=2'b01 with wr_valid to thread 0 -> write rejected, next cycle empty[0]=1, thread 1 head unchanged and readable.
- Assert reset low asynchronously between clock edges with both threads non-empty -> empty, full, rd_valid, rd_* reach reset values before the next rising edge.
- NUM_THREADS=3 build, wr_thread=rd_thread=3 -> wr_ready=0, rd_valid=0, rd_* =0, no state change in any thread.
